// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and sizes for the binarized window generator.
package bnn_pkg;
  localparam int WIN_K = 3;
  localparam int KERNEL_SIZE = WIN_K * WIN_K;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} wingen_state_t;
  typedef logic [KERNEL_SIZE-1:0] window_t;
endpackage

// File: rtl/bin_window_gen_if.sv
// bin_window_gen_if: pixel stream in, window strobe out; master drives pixels, slave is the generator.
interface bin_window_gen_if import bnn_pkg::*; #(parameter int KS = KERNEL_SIZE);
  logic frame_start;
  logic pixel_valid;
  logic pixel_in;
  logic window_valid;
  logic [KS-1:0] window_out;
  logic frame_done;
  logic busy;
  modport master (output frame_start, pixel_valid, pixel_in, input window_valid, window_out, frame_done, busy);
  modport slave (input frame_start, pixel_valid, pixel_in, output window_valid, window_out, frame_done, busy);
endinterface

// File: rtl/bin_line_buffer.sv
// bin_line_buffer: DEPTH-deep 1-bit delay line that advances only when enabled.
module bin_line_buffer #(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH:0] sr_sh;
    assign sr_sh = {sr_q, d_i};
    assign q_o = sr_q[DEPTH-1];
    always_ff @(posedge clock or posedge reset)
        if (reset) sr_q <= '0;
        else if (en_i) sr_q <= sr_sh[DEPTH-1:0];
endmodule

// File: rtl/bin_window_gen.sv
// bin_window_gen: raster bitstream to KxK window strobes for the XNOR/popcount stage.
// Define WINGEN_STRIDE2_EN to emit only stride-2 windows.
module bin_window_gen import bnn_pkg::*; #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int K          = 3
) (
    input logic clock,
    input logic reset,
    bin_window_gen_if.slave bus
);
    localparam int KS = K * K;
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_K1 = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_K1 = RW'(K - 1);

    wingen_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic [KS-1:0] win_q, win_d, win_sh;
    logic valid_q, valid_d, done_q, done_d;
    logic acc, last, in_win, stride_ok;
    // lb_tap[0] is the live pixel, lb_tap[i] is the same column i rows above
    logic [K-1:0] lb_tap;

    assign acc = bus.pixel_valid;
    assign lb_tap[0] = bus.pixel_in;

    genvar i, r, c;
    for (i = 0; i < K - 1; i++) begin : g_lb
        bin_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
            .clock(clock),
            .reset(reset),
            .en_i (acc),
            .d_i  (lb_tap[i]),
            .q_o  (lb_tap[i+1])
        );
    end

    for (r = 0; r < K; r++) begin : g_row
        for (c = 0; c < K; c++) begin : g_col
            if (c == K - 1) begin : g_new
                assign win_sh[r*K+c] = lb_tap[K-1-r];
            end else begin : g_shift
                assign win_sh[r*K+c] = win_q[r*K+c+1];
            end
        end
    end

`ifdef WINGEN_STRIDE2_EN
    assign stride_ok = (row_cur[0] == ROW_K1[0]) && (col_cur[0] == COL_K1[0]);
`else
    assign stride_ok = 1'b1;
`endif

    always_comb begin
        col_cur = bus.frame_start ? '0 : col_q;
        row_cur = bus.frame_start ? '0 : row_q;
        last = (col_cur == COL_LAST) && (row_cur == ROW_LAST);
        in_win = (row_cur >= ROW_K1) && (col_cur >= COL_K1);
        col_d = col_cur;
        row_d = row_cur;
        state_d = bus.frame_start ? IDLE : state_q;
        if (acc) begin
            col_d = (col_cur == COL_LAST) ? '0 : col_cur + 1'b1;
            row_d = (col_cur != COL_LAST) ? row_cur : last ? '0 : row_cur + 1'b1;
            state_d = last ? IDLE : (row_d >= ROW_K1) ? STREAM : FILL;
        end
        win_d = acc ? win_sh : win_q;
        valid_d = acc && in_win && stride_ok;
        done_d = acc && last;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            valid_q <= valid_d;
            done_q <= done_d;
        end

    assign bus.window_valid = valid_q;
    assign bus.window_out = win_q;
    assign bus.frame_done = done_q;
    assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_bin_window_gen.sv
// tb_bin_window_gen: directed frames on a 4x4 generator and a 5x5 one (stride check).
module tb_bin_window_gen;
    import bnn_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    window_t wins[16];
    int pos[16];
    int ns, nd, ds, bf, bl;

    always #5 clock = ~clock;

    bin_window_gen_if a ();
    bin_window_gen_if b ();

    bin_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .K(3)) dut_a (.clock(clock), .reset(reset), .bus(a.slave));
    bin_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3)) dut_b (.clock(clock), .reset(reset), .bus(b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int sel, input logic pv, input logic pi, input logic fs,
                        output logic wv, output logic wd, output logic bz, output window_t wo);
        if (sel == 0) begin
            a.pixel_valid = pv; a.pixel_in = pi; a.frame_start = fs;
        end else begin
            b.pixel_valid = pv; b.pixel_in = pi; b.frame_start = fs;
        end
        @(posedge clock);
        #1;
        wv = sel == 0 ? a.window_valid : b.window_valid;
        wd = sel == 0 ? a.frame_done : b.frame_done;
        bz = sel == 0 ? a.busy : b.busy;
        wo = sel == 0 ? a.window_out : b.window_out;
    endtask

    task automatic run_frame(input int sel, input int w, input int h, input int one_idx, input bit gap,
                             input bit fs_first, output int nstr, output int ndone, output int dstr,
                             output int busy_first, output int busy_last);
        logic wv, wd, bz;
        window_t wo;
        nstr = 0; ndone = 0; dstr = -1; busy_first = -1; busy_last = -1;
        for (int idx = 0; idx < w * h; idx++) begin
            step(sel, 1'b1, (one_idx < 0) || (idx == one_idx), fs_first && idx == 0, wv, wd, bz, wo);
            if (idx == 0) busy_first = int'(bz);
            if (idx == w * h - 1) busy_last = int'(bz);
            if (wv) begin
                if (nstr < 16) begin
                    wins[nstr] = wo;
                    pos[nstr] = idx;
                end
                nstr++;
            end
            if (wd) begin
                ndone++;
                if (wv) dstr = nstr;
            end
            if (gap) begin
                step(sel, 1'b0, 1'b1, 1'b0, wv, wd, bz, wo);
                chk("gap_no_strobe", {31'b0, wv}, 32'd0);
            end
        end
        step(sel, 1'b0, 1'b0, 1'b0, wv, wd, bz, wo);
        chk("strobe_drops", {30'b0, wv, wd}, 32'd0);
    endtask

    initial begin
        logic wv, wd, bz;
        window_t wo;
        a.pixel_valid = 0; a.pixel_in = 0; a.frame_start = 0;
        b.pixel_valid = 0; b.pixel_in = 0; b.frame_start = 0;
        #12;
        chk("rst_valid", {31'b0, a.window_valid}, 32'd0);
        chk("rst_window", {23'b0, a.window_out}, 32'd0);
        chk("rst_done", {31'b0, a.frame_done}, 32'd0);
        chk("rst_busy", {31'b0, a.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(0, 4, 4, -1, 1'b0, 1'b0, ns, nd, ds, bf, bl);
        chk("ones_count", ns, 4);
        for (int k = 0; k < 4; k++) chk("ones_win", {23'b0, wins[k]}, 32'h1FF);
        chk("ones_pos0", pos[0], 10);
        chk("ones_pos1", pos[1], 11);
        chk("ones_pos2", pos[2], 14);
        chk("ones_pos3", pos[3], 15);
        chk("ones_done", nd, 1);
        chk("ones_done_at4", ds, 4);
        chk("busy_first", bf, 1);
        chk("busy_last", bl, 0);
        chk("hold_window", {23'b0, a.window_out}, 32'h1FF);
        run_frame(0, 4, 4, 0, 1'b0, 1'b0, ns, nd, ds, bf, bl);
        chk("one0_count", ns, 4);
        chk("one0_w0", {23'b0, wins[0]}, 32'h001);
        chk("one0_w1", {23'b0, wins[1]}, 32'h000);
        chk("one0_w2", {23'b0, wins[2]}, 32'h000);
        chk("one0_w3", {23'b0, wins[3]}, 32'h000);
        run_frame(0, 4, 4, 5, 1'b0, 1'b0, ns, nd, ds, bf, bl);
        chk("one5_w0", {23'b0, wins[0]}, 32'h010);
        chk("one5_w1", {23'b0, wins[1]}, 32'h008);
        chk("one5_w2", {23'b0, wins[2]}, 32'h002);
        chk("one5_w3", {23'b0, wins[3]}, 32'h001);
        chk("one5_hold", {23'b0, a.window_out}, 32'h001);
        run_frame(0, 4, 4, -1, 1'b1, 1'b0, ns, nd, ds, bf, bl);
        chk("gap_count", ns, 4);
        for (int k = 0; k < 4; k++) chk("gap_win", {23'b0, wins[k]}, 32'h1FF);
        chk("gap_pos3", pos[3], 15);
        chk("gap_done_at4", ds, 4);
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 1'b1, 1'b1, 1'b0, wv, wd, bz, wo);
            if (wd) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_busy", {31'b0, bz}, 32'd1);
        run_frame(0, 4, 4, -1, 1'b0, 1'b1, ns, nd, ds, bf, bl);
        chk("restart_count", ns, 4);
        chk("restart_done", nd, 1);
        chk("restart_pos0", pos[0], 10);
        for (int k = 0; k < 7; k++) step(0, 1'b1, 1'b1, 1'b0, wv, wd, bz, wo);
        chk("pre_reset_busy", {31'b0, bz}, 32'd1);
        a.pixel_valid = 0;
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'b0, a.window_valid}, 32'd0);
        chk("async_window", {23'b0, a.window_out}, 32'd0);
        chk("async_done", {31'b0, a.frame_done}, 32'd0);
        chk("async_busy", {31'b0, a.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(0, 4, 4, -1, 1'b0, 1'b0, ns, nd, ds, bf, bl);
        chk("post_reset_count", ns, 4);
        chk("post_reset_pos0", pos[0], 10);
        for (int k = 0; k < 4; k++) chk("post_reset_win", {23'b0, wins[k]}, 32'h1FF);
        chk("post_reset_done_at4", ds, 4);
        run_frame(1, 5, 5, -1, 1'b0, 1'b0, ns, nd, ds, bf, bl);
        chk("s5_done", nd, 1);
        chk("s5_pos0", pos[0], 12);
        chk("s5_win0", {23'b0, wins[0]}, 32'h1FF);
`ifdef WINGEN_STRIDE2_EN
        chk("s5_count", ns, 4);
        chk("s5_pos1", pos[1], 14);
        chk("s5_pos2", pos[2], 22);
        chk("s5_pos3", pos[3], 24);
        chk("s5_done_at", ds, 4);
`else
        chk("s5_count", ns, 9);
        chk("s5_pos1", pos[1], 13);
        chk("s5_pos8", pos[8], 24);
        chk("s5_done_at", ds, 9);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
